// File: rtl/postproc_sched_if.sv
// Handshake bundle between the FMA/divsqrt requesters, the post-processing datapath and writeback.
// Latency: none, wires only.
// Backpressure: carried by FmaReady/DivReady toward the requesters and ResReady from writeback.
interface postproc_sched_if #(
  parameter int TAGW = 5
);
  logic            FmaValid;
  logic [TAGW-1:0] FmaTag;
  logic            FmaReady;
  logic            DivValid;
  logic [TAGW-1:0] DivTag;
  logic            DivReady;
  logic            Flush;
  logic            S1En;
  logic            S1SelDiv;
  logic            FmaOp;
  logic            DivOp;
  logic            S2En;
  logic            ResValid;
  logic [TAGW-1:0] ResTag;
  logic            ResIsDiv;
  logic            ResReady;

  // Requester / writeback side: drives requests, flush and ResReady.
  modport master (
    output FmaValid, FmaTag, DivValid, DivTag, Flush, ResReady,
    input  FmaReady, DivReady, S1En, S1SelDiv, FmaOp, DivOp, S2En,
    input  ResValid, ResTag, ResIsDiv
  );

  // Scheduler side.
  modport slave (
    input  FmaValid, FmaTag, DivValid, DivTag, Flush, ResReady,
    output FmaReady, DivReady, S1En, S1SelDiv, FmaOp, DivOp, S2En,
    output ResValid, ResTag, ResIsDiv
  );
endinterface

// File: rtl/postproc_sched.sv
// Arbitrates FMA and divsqrt results into a shared two-stage (shift, round) post-processing pipe.
// Latency: grant at edge N -> stage-1 op in cycle N+1, result valid in cycle N+2; one op per cycle.
// Backpressure: ResReady low stalls S2, then S1, then withholds grants; divsqrt is forced after STARVE_MAX lost conflicts.
module postproc_sched #(
  parameter int TAGW       = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            reset,
  postproc_sched_if.slave bus
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic            v1_q, v1_d;
  logic            div1_q, div1_d;
  logic [TAGW-1:0] tag1_q, tag1_d;
  logic            v2_q, v2_d;
  logic            div2_q, div2_d;
  logic [TAGW-1:0] tag2_q, tag2_d;
  logic [2:0]      wait_q, wait_d;

  logic adv2, adv1, slot, fma_gnt, div_gnt;

  // Pipeline advance and grant arbitration; reset and flush suppress every grant.
  always_comb begin
    adv2    = ~v2_q | bus.ResReady;
    adv1    = v1_q & adv2 & ~reset;
    slot    = ~v1_q | adv2;
    fma_gnt = 1'b0;
    div_gnt = 1'b0;
    if (slot && !bus.Flush && !reset) begin
      if (bus.FmaValid && bus.DivValid) begin
        // FMA wins conflicts until divsqrt has waited STARVE_MAX times.
        div_gnt = (wait_q == STARVE_LIM);
        fma_gnt = ~div_gnt;
      end else begin
        fma_gnt = bus.FmaValid;
        div_gnt = bus.DivValid;
      end
    end
  end

  // Next-state for both stages and the starvation counter.
  always_comb begin
    v1_d   = v1_q;
    div1_d = div1_q;
    tag1_d = tag1_q;
    v2_d   = v2_q;
    div2_d = div2_q;
    tag2_d = tag2_q;
    wait_d = wait_q;

    // Stage 2: take stage 1 when it advances, otherwise drain on ResReady.
    if (adv1) begin
      v2_d   = 1'b1;
      div2_d = div1_q;
      tag2_d = tag1_q;
    end else if (v2_q && bus.ResReady) begin
      v2_d = 1'b0;
    end

    // Stage 1: load the granted request, otherwise empty out as it advances.
    if (fma_gnt || div_gnt) begin
      v1_d   = 1'b1;
      div1_d = div_gnt;
      tag1_d = div_gnt ? bus.DivTag : bus.FmaTag;
    end else if (adv1) begin
      v1_d = 1'b0;
    end

    if (bus.Flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end

    // Counter only tracks divsqrt losing to FMA; anything else restarts the count.
    if (bus.Flush || div_gnt || !bus.DivValid) begin
      wait_d = 3'd0;
    end else if (bus.FmaValid && fma_gnt && (wait_q != STARVE_LIM)) begin
      wait_d = wait_q + 3'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      div1_q <= 1'b0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      div2_q <= 1'b0;
      tag2_q <= '0;
      wait_q <= 3'd0;
    end else begin
      v1_q   <= v1_d;
      div1_q <= div1_d;
      tag1_q <= tag1_d;
      v2_q   <= v2_d;
      div2_q <= div2_d;
      tag2_q <= tag2_d;
      wait_q <= wait_d;
    end
  end

  // Output decode.
  always_comb begin
    bus.FmaReady = fma_gnt;
    bus.DivReady = div_gnt;
    bus.S1En     = fma_gnt | div_gnt;
    bus.S1SelDiv = div_gnt;
    bus.FmaOp    = v1_q & ~div1_q;
    bus.DivOp    = v1_q & div1_q;
    bus.S2En     = adv1;
    bus.ResValid = v2_q;
    bus.ResTag   = tag2_q;
    bus.ResIsDiv = div2_q;
  end

endmodule

// File: tb/tb_postproc_sched.sv
// Bench for postproc_sched: directed scenarios then random traffic against a cycle reference model.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: ResReady is randomized to exercise stalls.
module tb_postproc_sched;

  localparam int TAGW   = 5;
  localparam int STARVE = 3;

  typedef struct packed {
    logic            v;
    logic            dv;
    logic [TAGW-1:0] tag;
  } stage_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  postproc_sched_if #(.TAGW(TAGW)) bus ();

  postproc_sched #(.TAGW(TAGW), .STARVE_MAX(STARVE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what occupies each stage and how long divsqrt has lost.
  stage_t m_s1 = '0;
  stage_t m_s2 = '0;
  int     m_wait = 0;

  // Last observed DUT outputs, for directed checks.
  logic            obs_fr, obs_dr, obs_s2en, obs_fop, obs_dop, obs_rv, obs_rdiv;
  logic [TAGW-1:0] obs_rtag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check all outputs against the model, then advance the model.
  task automatic step(input logic fv, input logic [TAGW-1:0] ft, input logic dv,
                      input logic [TAGW-1:0] dt, input logic fl, input logic rr,
                      input logic rst);
    logic   busy, accept, e_fg, e_dg, e_move;
    stage_t n_s1, n_s2;
    @(negedge clk);
    bus.FmaValid = fv;
    bus.FmaTag   = ft;
    bus.DivValid = dv;
    bus.DivTag   = dt;
    bus.Flush    = fl;
    bus.ResReady = rr;
    reset        = rst;
    #1;
    busy   = m_s2.v && !rr;
    accept = !m_s1.v || !busy;
    e_dg   = !rst && !fl && accept && dv && (!fv || m_wait == STARVE);
    e_fg   = !rst && !fl && accept && fv && !e_dg;
    e_move = !rst && m_s1.v && !busy;

    chk("FmaReady", 32'(bus.FmaReady), 32'(e_fg));
    chk("DivReady", 32'(bus.DivReady), 32'(e_dg));
    chk("S1En", 32'(bus.S1En), 32'(e_fg || e_dg));
    if (e_fg || e_dg) chk("S1SelDiv", 32'(bus.S1SelDiv), 32'(e_dg));
    chk("S2En", 32'(bus.S2En), 32'(e_move));
    chk("FmaOp", 32'(bus.FmaOp), 32'(m_s1.v && !m_s1.dv));
    chk("DivOp", 32'(bus.DivOp), 32'(m_s1.v && m_s1.dv));
    chk("ResValid", 32'(bus.ResValid), 32'(m_s2.v));
    if (m_s2.v) begin
      chk("ResTag", 32'(bus.ResTag), 32'(m_s2.tag));
      chk("ResIsDiv", 32'(bus.ResIsDiv), 32'(m_s2.dv));
    end

    obs_fr   = bus.FmaReady;
    obs_dr   = bus.DivReady;
    obs_s2en = bus.S2En;
    obs_fop  = bus.FmaOp;
    obs_dop  = bus.DivOp;
    obs_rv   = bus.ResValid;
    obs_rtag = bus.ResTag;
    obs_rdiv = bus.ResIsDiv;

    @(posedge clk);
    if (rst) begin
      m_s1   = '0;
      m_s2   = '0;
      m_wait = 0;
    end else begin
      n_s1 = m_s1;
      n_s2 = m_s2;
      if (e_move) n_s2 = m_s1;
      else if (m_s2.v && rr) n_s2.v = 1'b0;
      if (e_fg || e_dg) begin
        n_s1.v   = 1'b1;
        n_s1.dv  = e_dg;
        n_s1.tag = e_dg ? dt : ft;
      end else if (e_move) begin
        n_s1.v = 1'b0;
      end
      if (fl) begin
        n_s1.v = 1'b0;
        n_s2.v = 1'b0;
      end
      if (fl || e_dg || !dv) m_wait = 0;
      else if (fv && e_fg && m_wait < STARVE) m_wait = m_wait + 1;
      m_s1 = n_s1;
      m_s2 = n_s2;
    end
  endtask

  task automatic idle(input logic rr);
    step(1'b0, '0, 1'b0, '0, 1'b0, rr, 1'b0);
  endtask

  initial begin
    bus.FmaValid = 1'b0;
    bus.FmaTag   = '0;
    bus.DivValid = 1'b0;
    bus.DivTag   = '0;
    bus.Flush    = 1'b0;
    bus.ResReady = 1'b0;
    reset        = 1'b1;
    @(posedge clk);

    // Held in reset with requests pending: nothing granted, nothing advances.
    step(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1);
    chk("rst_fr", 32'(obs_fr), 32'd0);
    chk("rst_rv", 32'(obs_rv), 32'd0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Single FMA, tag 5.
    step(1'b1, 5'd5, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("single_fr", 32'(obs_fr), 32'd1);
    idle(1'b1);
    chk("single_fop", 32'(obs_fop), 32'd1);
    idle(1'b1);
    chk("single_rv", 32'(obs_rv), 32'd1);
    chk("single_tag", 32'(obs_rtag), 32'd5);
    chk("single_div", 32'(obs_rdiv), 32'd0);

    // Both requesting every cycle: F,F,F,D repeating.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'(i), 1'b1, 5'(16 + i), 1'b0, 1'b1, 1'b0);
      chk("starve_dr", 32'(obs_dr), 32'((i % 4) == 3));
      chk("starve_fr", 32'(obs_fr), 32'((i % 4) != 3));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill the pipe under backpressure, hold, then release.
    step(1'b1, 5'd11, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd12, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd13, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("bp_fr", 32'(obs_fr), 32'd0);
      chk("bp_s2en", 32'(obs_s2en), 32'd0);
      chk("bp_tag", 32'(obs_rtag), 32'd11);
    end
    step(1'b1, 5'd13, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("pop_rv", 32'(obs_rv), 32'd1);
    chk("pop_fr", 32'(obs_fr), 32'd1);

    // Pipe is full again (12 in S2, 13 in S1): flush it with divsqrt waiting.
    step(1'b0, '0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    chk("flush_dr", 32'(obs_dr), 32'd0);
    idle(1'b1);
    chk("flush_fop", 32'(obs_fop), 32'd0);
    chk("flush_dop", 32'(obs_dop), 32'd0);
    chk("flush_rv", 32'(obs_rv), 32'd0);

    // Reset mid-flight, then a divsqrt op with tag 9.
    step(1'b1, 5'd3, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd4, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("rstmid_rv", 32'(obs_rv), 32'd0);
    chk("rstmid_fop", 32'(obs_fop), 32'd0);
    step(1'b0, '0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    chk("div9_dr", 32'(obs_dr), 32'd1);
    idle(1'b1);
    chk("div9_dop", 32'(obs_dop), 32'd1);
    idle(1'b1);
    chk("div9_rv", 32'(obs_rv), 32'd1);
    chk("div9_div", 32'(obs_rdiv), 32'd1);
    chk("div9_tag", 32'(obs_rtag), 32'd9);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom),
           1'($urandom_range(0, 2) != 0), 5'($urandom),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/postproc_sched.md
POSTPROC_SCHED -- requirements
Module: postproc_sched

Interface
REQ-001 Parameter TAGW, default 5: width of the destination/op tag carried with each result.
REQ-002 Parameter STARVE_MAX, default 3: FMA-won conflict cycles tolerated before divsqrt is forced a grant; legal range 1..7.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 FmaValid  input  1  FMA unit presents an unnormalized sum for post-processing.
REQ-006 FmaTag  input  TAGW  tag of the FMA request.
REQ-007 FmaReady  output  1  FMA request granted this cycle (combinational).
REQ-008 DivValid  input  1  divsqrt unit presents a finished quotient/root.
REQ-009 DivTag  input  TAGW  tag of the divsqrt request.
REQ-010 DivReady  output  1  divsqrt request granted this cycle (combinational).
REQ-011 Flush  input  1  kill all in-flight and waiting state.
REQ-012 S1En  output  1  capture enable for the stage-1 (shift/shift-correction) operand registers.
REQ-013 S1SelDiv  output  1  stage-1 operand mux select: 1 = divsqrt operands, 0 = FMA operands; valid when S1En=1.
REQ-014 FmaOp  output  1  stage 1 holds a valid FMA op (drives the shift-correction FmaOp input).
REQ-015 DivOp  output  1  stage 1 holds a valid divsqrt op (drives the shift-correction DivOp input).
REQ-016 S2En  output  1  capture enable for the stage-2 (rounding) registers.
REQ-017 ResValid  output  1  stage-2 result valid toward writeback.
REQ-018 ResTag  output  TAGW  tag of the stage-2 result.
REQ-019 ResIsDiv  output  1  stage-2 result originated from divsqrt.
REQ-020 ResReady  input  1  writeback accepts the stage-2 result this cycle.

Function
REQ-021 The block SHALL hold two stage registers, S1 {V1, Div1, Tag1} and S2 {V2, Div2, Tag2}, plus a wait counter WaitCnt of 3 bits.
REQ-022 Adv2 = ~V2 | ResReady; Adv1 = V1 & Adv2; Slot = ~V1 | Adv2.
REQ-023 Grant: if Slot=0 or Flush=1, then no grant. If only one requester is valid, that requester is granted. If both are valid, divsqrt is granted when WaitCnt == STARVE_MAX and FMA is granted otherwise.
REQ-024 FmaReady/DivReady SHALL be the grant signals, mutually exclusive, and never asserted while Flush=1.
REQ-025 S1En = FmaReady | DivReady; S1SelDiv = DivReady.
REQ-026 On a grant, S1 loads V1=1, Div1=DivReady, and the granted tag at the next edge.
REQ-027 If Adv1=1 and there is no grant, V1 SHALL clear. If V1=1 and Adv2=0, S1 holds.
REQ-028 S2En = Adv1. When Adv1=1, S2 loads from S1. If V2=1, ResReady=1 and Adv1=0, V2 clears. If V2=1 and ResReady=0, S2 holds.
REQ-029 FmaOp = V1 & ~Div1; DivOp = V1 & Div1; ResValid = V2; ResTag = Tag2; ResIsDiv = Div2.
REQ-030 Latency: a grant at edge N gives FmaOp/DivOp=1 in cycle N+1 and ResValid=1 in cycle N+2 when there is no backpressure. Throughput is one op per cycle.
REQ-031 WaitCnt SHALL increment, saturating at STARVE_MAX, in a cycle where DivValid=1, FmaValid=1 and FmaReady=1.
REQ-032 WaitCnt SHALL clear on DivReady=1, on DivValid=0, or on Flush=1. Otherwise it holds, including when Slot=0.
REQ-033 Flush SHALL clear V1, V2 and WaitCnt at the next edge, regardless of ResReady or a pending grant.
REQ-034 During backpressure (V1=V2=1, ResReady=0), there SHALL be no grant and no register change except WaitCnt clearing per REQ-032.
REQ-035 Tags SHALL pass through unmodified. Stage contents are don't-care when their valid bit is 0, but tags SHALL only update on their load conditions.
REQ-036 Requesters SHALL be allowed to drop Valid without a grant; the block holds no memory of an ungranted request except WaitCnt.

Reset
REQ-037 With reset=1 at a rising edge: V1=0, V2=0, WaitCnt=0, Div1=Div2=0, Tag1=Tag2=0.
REQ-038 While reset=1: FmaReady=DivReady=S1En=S2En=0, and FmaOp=DivOp=ResValid=0 from the first edge.
REQ-039 Reset asserted mid-operation SHALL discard all in-flight ops with no ResValid pulse. Reset SHALL take priority over Flush and all grants.

Verification
REQ-040 Single FMA request, tag 5, ResReady=1 -> FmaReady=1 at cycle 0; FmaOp=1 at cycle 1; ResValid=1, ResTag=5, ResIsDiv=0 at cycle 2.
REQ-041 FMA and Div both held valid every cycle, STARVE_MAX=3, ResReady=1 -> grant sequence F,F,F,D,F,F,F,D...; WaitCnt reads 0,1,2,3,0 across the first five edges.
REQ-042 Pipeline full, ResReady=0 for 4 cycles, FMA valid -> FmaReady=0 and S2En=0 throughout; ResTag stable. ResReady=1 -> the next result pops and FmaReady=1 in the same cycle.
REQ-043 Flush with V1=V2=1 and DivValid=1 -> DivReady=0 that cycle; V1=V2=0 and WaitCnt=0 next cycle; no ResValid for the flushed ops.
REQ-044 Reset asserted while V1=1 and V2=1 -> all outputs 0 after the edge. After release, a Div request tag 9 -> ResValid, ResIsDiv=1, ResTag=9 two cycles after its grant.
